// File: rtl/dut_pkg.sv
// Shared constants and types for the dut result path.
package dut_pkg;

  localparam int unsigned DUT_DATA_W    = 256;
  localparam int unsigned DUT_WORD_W    = 32;
  localparam int unsigned DUT_NUM_WORDS = 8;
  localparam int unsigned DUT_IDX_W     = 3;
  localparam int unsigned DUT_CNT_W     = 16;

  typedef logic [DUT_DATA_W-1:0] dut_blk_t;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } ser_state_e;

endpackage

// File: rtl/dut_out_serializer_if.sv
// Result-in / word-out stream bundle of the output serializer.
interface dut_out_serializer_if
  import dut_pkg::*;
#(
  parameter int unsigned WORD_W    = DUT_WORD_W,
  parameter int unsigned NUM_WORDS = DUT_NUM_WORDS
);

  logic                        in_vld;
  logic [WORD_W*NUM_WORDS-1:0] in_data;
  logic                        in_busy;
  logic                        out_vld;
  logic [WORD_W-1:0]           out_data;
  logic [DUT_IDX_W-1:0]        out_idx;
  logic                        out_last;
  logic                        out_busy;
  logic [DUT_CNT_W-1:0]        blk_cnt;

  // Serializer side.
  modport master (
    input  in_vld,
    input  in_data,
    output in_busy,
    output out_vld,
    output out_data,
    output out_idx,
    output out_last,
    input  out_busy,
    output blk_cnt
  );

  // Upstream producer / downstream sink side.
  modport slave (
    output in_vld,
    output in_data,
    input  in_busy,
    input  out_vld,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_busy,
    input  blk_cnt
  );

endinterface

// File: rtl/dut_out_serializer.sv
// Splits each wide dut result into NUM_WORDS words on a vld/busy stream, overlapping the
// next accept with the last word so consecutive blocks stream without a bubble.
module dut_out_serializer
  import dut_pkg::*;
#(
  parameter int unsigned WORD_W    = DUT_WORD_W,
  parameter int unsigned NUM_WORDS = DUT_NUM_WORDS,
  parameter bit          LSW_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  dut_out_serializer_if.master bus
);

  localparam int unsigned          DataW   = WORD_W * NUM_WORDS;
  localparam logic [DUT_IDX_W-1:0] LastIdx = DUT_IDX_W'(NUM_WORDS - 1);

  ser_state_e           state_q, state_d;
  logic [DataW-1:0]     data_q, data_d;
  logic [DUT_IDX_W-1:0] idx_q, idx_d;
  logic [DUT_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  logic              full;
  logic              out_vld;
  logic              out_last;
  logic              out_xfer;
  logic              in_busy;
  logic              in_xfer;
  logic [WORD_W-1:0] head_word;

  // Outputs are masked while rst is high so a word cannot be taken on the reset edge.
  assign full     = (state_q == StFull);
  assign out_vld  = full & ~rst;
  assign out_last = out_vld & (idx_q == LastIdx);
  assign out_xfer = out_vld & ~bus.out_busy;
  assign in_busy  = rst | (full & ~(out_xfer & out_last));
  assign in_xfer  = bus.in_vld & ~in_busy;

  assign head_word = LSW_FIRST ? data_q[WORD_W-1:0] : data_q[DataW-1 -: WORD_W];

  assign bus.in_busy  = in_busy;
  assign bus.out_vld  = out_vld;
  assign bus.out_last = out_last;
  assign bus.out_idx  = out_vld ? idx_q : '0;
  assign bus.out_data = out_vld ? head_word : '0;
  assign bus.blk_cnt  = blk_cnt_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    blk_cnt_d = blk_cnt_q;

    if (out_xfer) begin
      if (out_last) begin
        blk_cnt_d = blk_cnt_q + DUT_CNT_W'(1);
        state_d   = StEmpty;
        data_d    = '0;
        idx_d     = '0;
      end else begin
        idx_d  = idx_q + DUT_IDX_W'(1);
        data_d = LSW_FIRST ? (data_q >> WORD_W) : (data_q << WORD_W);
      end
    end

    // A new block overrides the drain of the previous one on the same edge.
    if (in_xfer) begin
      state_d = StFull;
      data_d  = bus.in_data;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      data_q    <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_dut_out_serializer.sv
// Self-checking bench for dut_out_serializer: directed scenarios plus a randomized
// run against a queue-based word model.
module tb_dut_out_serializer;
  import dut_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dut_out_serializer_if #(.WORD_W(32), .NUM_WORDS(8)) bus_l ();
  dut_out_serializer_if #(.WORD_W(32), .NUM_WORDS(8)) bus_m ();
  dut_out_serializer_if #(.WORD_W(32), .NUM_WORDS(1)) bus_w ();

  dut_out_serializer #(.WORD_W(32), .NUM_WORDS(8), .LSW_FIRST(1'b1)) u_lsw (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.master)
  );

  dut_out_serializer #(.WORD_W(32), .NUM_WORDS(8), .LSW_FIRST(1'b0)) u_msw (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.master)
  );

  dut_out_serializer #(.WORD_W(32), .NUM_WORDS(1), .LSW_FIRST(1'b1)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.master)
  );

  function automatic dut_blk_t mk_blk(input logic [31:0] base);
    dut_blk_t b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [54:0] got;
    rst = 1'b1;
    step();
    #1;
    n_tests++;
    if (bus_l.in_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_busy: got %b want 1", bus_l.in_busy);
    end
    got = {bus_l.out_vld, bus_l.out_last, bus_l.out_idx, bus_l.out_data, bus_l.blk_cnt};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    rst = 1'b0;
    step();
    #1;
    got = {bus_l.out_vld, bus_l.out_last, bus_l.out_idx, bus_l.out_data, bus_l.blk_cnt};
    n_tests++;
    if ({got, bus_l.in_busy} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h want 0", {got, bus_l.in_busy});
    end
  endtask

  task automatic test_single();
    logic [36:0] got, exp;
    do_reset();
    bus_l.in_vld  = 1'b1;
    bus_l.in_data = mk_blk(32'h0);
    #1;
    n_tests++;
    if (bus_l.in_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept_ready: got in_busy %b want 0", bus_l.in_busy);
    end
    step();
    bus_l.in_vld  = 1'b0;
    bus_l.in_data = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = {1'b1, (k == 7), 3'(k), 32'(k)};
      got = {bus_l.out_vld, bus_l.out_last, bus_l.out_idx, bus_l.out_data};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_word%0d: got %h want %h", k, got, exp);
      end
      step();
    end
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.out_data, bus_l.blk_cnt} !== {1'b0, 32'h0, 16'd1}) begin
      n_fail++;
      $display("FAIL single_done: vld %b data %h blk_cnt %0d want 0/0/1",
               bus_l.out_vld, bus_l.out_data, bus_l.blk_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] got, exp;
    do_reset();
    bus_l.in_vld  = 1'b1;
    bus_l.in_data = mk_blk(32'h0);
    step();
    bus_l.in_data = mk_blk(32'h10);
    for (int c = 0; c < 16; c++) begin
      #1;
      exp = {1'b1, (c % 8 == 7), 3'(c % 8), (c < 8) ? 32'(c) : 32'(c + 8),
             !(c == 7 || c == 15)};
      got = {bus_l.out_vld, bus_l.out_last, bus_l.out_idx, bus_l.out_data, bus_l.in_busy};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got %h want %h", c, got, exp);
      end
      step();
      if (c == 7) bus_l.in_vld = 1'b0;
    end
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.blk_cnt} !== {1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL b2b_done: vld %b blk_cnt %0d want 0/2", bus_l.out_vld, bus_l.blk_cnt);
    end
  endtask

  task automatic test_stall();
    int unsigned busy_pat [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    int unsigned idx_pat  [11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};
    logic [37:0] got, exp;
    do_reset();
    bus_l.in_vld  = 1'b1;
    bus_l.in_data = mk_blk(32'h0);
    step();
    bus_l.in_data = mk_blk(32'h20);
    for (int i = 0; i < 11; i++) begin
      bus_l.out_busy = busy_pat[i][0];
      #1;
      exp = {1'b1, (idx_pat[i] == 7), 3'(idx_pat[i]), 32'(idx_pat[i]),
             !(busy_pat[i] == 0 && idx_pat[i] == 7)};
      got = {bus_l.out_vld, bus_l.out_last, bus_l.out_idx, bus_l.out_data, bus_l.in_busy};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got %h want %h", i, got, exp);
      end
      step();
    end
    bus_l.in_vld = 1'b0;
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.out_idx, bus_l.out_data} !== {1'b1, 3'd0, 32'h20}) begin
      n_fail++;
      $display("FAIL stall_next_block: vld %b idx %0d data %h want 1/0/20",
               bus_l.out_vld, bus_l.out_idx, bus_l.out_data);
    end
    for (int i = 0; i < 8; i++) step();
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.blk_cnt} !== {1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL stall_done: vld %b blk_cnt %0d want 0/2", bus_l.out_vld, bus_l.blk_cnt);
    end
  endtask

  task automatic test_msw();
    logic [36:0] got, exp;
    do_reset();
    bus_m.in_vld  = 1'b1;
    bus_m.in_data = mk_blk(32'h0);
    step();
    bus_m.in_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = {1'b1, (k == 7), 3'(k), 32'(7 - k)};
      got = {bus_m.out_vld, bus_m.out_last, bus_m.out_idx, bus_m.out_data};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL msw_word%0d: got %h want %h", k, got, exp);
      end
      step();
    end
    #1;
    n_tests++;
    if ({bus_m.out_vld, bus_m.blk_cnt} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL msw_done: vld %b blk_cnt %0d want 0/1", bus_m.out_vld, bus_m.blk_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_l.in_vld  = 1'b1;
    bus_l.in_data = mk_blk(32'h40);
    step();
    bus_l.in_vld = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.out_idx, bus_l.out_data} !== {1'b1, 3'd3, 32'h43}) begin
      n_fail++;
      $display("FAIL midrst_pre: vld %b idx %0d data %h want 1/3/43",
               bus_l.out_vld, bus_l.out_idx, bus_l.out_data);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.in_busy, bus_l.out_data} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL midrst_during: vld %b in_busy %b data %h want 0/1/0",
               bus_l.out_vld, bus_l.in_busy, bus_l.out_data);
    end
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.out_idx, bus_l.blk_cnt} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL midrst_after: vld %b idx %0d blk_cnt %0d want 0/0/0",
               bus_l.out_vld, bus_l.out_idx, bus_l.blk_cnt);
    end
    bus_l.in_vld  = 1'b1;
    bus_l.in_data = mk_blk(32'h50);
    step();
    bus_l.in_vld = 1'b0;
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.out_idx, bus_l.out_data} !== {1'b1, 3'd0, 32'h50}) begin
      n_fail++;
      $display("FAIL midrst_restart: vld %b idx %0d data %h want 1/0/50",
               bus_l.out_vld, bus_l.out_idx, bus_l.out_data);
    end
    for (int k = 0; k < 8; k++) step();
    #1;
    n_tests++;
    if ({bus_l.out_vld, bus_l.blk_cnt} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL midrst_done: vld %b blk_cnt %0d want 0/1", bus_l.out_vld, bus_l.blk_cnt);
    end
  endtask

  // Model: each accepted block becomes 8 queued words; the serializer can take a new block
  // only when at most its final word is left and that word leaves on the same edge.
  task automatic test_random();
    exp_t        q[$];
    exp_t        head, got;
    dut_blk_t    blk;
    logic        pending = 1'b0;
    logic        exp_busy, in_acc;
    int unsigned blocks_done = 0;
    int unsigned accepted    = 0;
    do_reset();
    bus_l.in_vld   = 1'b0;
    bus_l.out_busy = 1'b0;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      if (cyc >= 1500 && !pending && q.size() == 0) break;
      if (!pending && cyc < 1500 && $urandom_range(0, 3) != 0) begin
        for (int w = 0; w < 8; w++) blk[w*32 +: 32] = $urandom();
        bus_l.in_data = blk;
        pending = 1'b1;
      end
      bus_l.in_vld   = pending;
      bus_l.out_busy = (cyc < 1500) ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      exp_busy = !(q.size() == 0 || (q.size() == 1 && !bus_l.out_busy));
      n_tests++;
      if (bus_l.in_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rand_in_busy cyc%0d: got %b want %b", cyc, bus_l.in_busy, exp_busy);
      end
      got = {bus_l.out_data, bus_l.out_idx, bus_l.out_last};
      n_tests++;
      if (q.size() != 0) begin
        head = q[0];
        if (bus_l.out_vld !== 1'b1 || got !== head) begin
          n_fail++;
          $display("FAIL rand_word cyc%0d: vld %b got %h want 1/%h", cyc, bus_l.out_vld, got,
                   head);
        end
      end else if (bus_l.out_vld !== 1'b0 || got !== '0) begin
        n_fail++;
        $display("FAIL rand_idle cyc%0d: vld %b got %h want 0/0", cyc, bus_l.out_vld, got);
      end
      in_acc = pending && !exp_busy;
      if (q.size() != 0 && !bus_l.out_busy) begin
        if (q[0].last) blocks_done++;
        void'(q.pop_front());
      end
      if (in_acc) begin
        for (int k = 0; k < 8; k++)
          q.push_back('{data: bus_l.in_data[k*32 +: 32], idx: 3'(k), last: (k == 7)});
        accepted++;
        pending = 1'b0;
      end
      step();
    end
    bus_l.in_vld = 1'b0;
    #1;
    n_tests++;
    if (q.size() != 0 || accepted == 0 || bus_l.blk_cnt !== 16'(blocks_done)) begin
      n_fail++;
      $display("FAIL rand_summary: left %0d accepted %0d blk_cnt %0d want 0/>0/%0d",
               q.size(), accepted, bus_l.blk_cnt, blocks_done);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus_w.in_vld   = 1'b1;
    bus_w.out_busy = 1'b0;
    bus_w.in_data  = 32'hA5A5_0001;
    step();
    for (int c = 1; c < 65536; c++) step();
    #1;
    n_tests++;
    if ({bus_w.out_vld, bus_w.out_last, bus_w.out_idx, bus_w.out_data, bus_w.blk_cnt} !==
        {1'b1, 1'b1, 3'd0, 32'hA5A5_0001, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL wrap_pre: vld %b last %b idx %0d data %h blk_cnt %h want 1/1/0/a5a50001/ffff",
               bus_w.out_vld, bus_w.out_last, bus_w.out_idx, bus_w.out_data, bus_w.blk_cnt);
    end
    bus_w.in_vld = 1'b0;
    step();
    #1;
    n_tests++;
    if ({bus_w.out_vld, bus_w.blk_cnt} !== {1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL wrap_post: vld %b blk_cnt %h want 0/0000", bus_w.out_vld, bus_w.blk_cnt);
    end
  endtask

  initial begin
    bus_l.in_vld = 1'b0; bus_l.in_data = '0; bus_l.out_busy = 1'b0;
    bus_m.in_vld = 1'b0; bus_m.in_data = '0; bus_m.out_busy = 1'b0;
    bus_w.in_vld = 1'b0; bus_w.in_data = '0; bus_w.out_busy = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_msw();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
